// File: rtl/dispatch_tagger_pkg.sv
// rtl/dispatch_tagger_pkg.sv - shared tag constants and dout field layout for dispatch_tagger
package dispatch_tagger_pkg;

  localparam int TAG_W = 4;
  localparam logic [TAG_W-1:0] NO_TAG = 4'hF;

  localparam int DST_LSB = 0;
  localparam int SRC_B_LSB = 4;
  localparam int SRC_A_LSB = 8;
  localparam int PAYLOAD_LSB = 12;
  localparam int TAG_FIELDS_W = 12;

  localparam int DEF_PAYLOAD_WIDTH = 35;
  localparam int INSTR_W = DEF_PAYLOAD_WIDTH + TAG_FIELDS_W;

  // Out-of-range tags (including NO_TAG) carry no meaning to the pool or flags.
  function automatic logic tag_in_range(input logic [TAG_W-1:0] tag, input int num_tags);
    return int'(tag) < num_tags;
  endfunction

endpackage

// File: rtl/dispatch_tagger_tag_free_pool.sv
// rtl/dispatch_tagger_tag_free_pool.sv - free-tag mask with lowest-free allocation
module tag_free_pool
  import dispatch_tagger_pkg::*;
#(
  parameter int NUM_TAGS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_en,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             empty,
  input  logic             free_en,
  input  logic [TAG_W-1:0] free_tag
);

  logic [NUM_TAGS-1:0] mask_q, mask_d;

  always_comb begin
    alloc_tag = NO_TAG;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (mask_q[i]) alloc_tag = TAG_W'(i);
    end
  end

  assign empty = ~|mask_q;

  // The allocation is chosen from the pre-update mask, so a tag freed this
  // cycle only becomes visible to the encoder on the following cycle.
  always_comb begin
    mask_d = mask_q;
    if (free_en && tag_in_range(free_tag, NUM_TAGS)) mask_d[free_tag] = 1'b1;
    if (alloc_en && !empty) mask_d[alloc_tag] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) mask_q <= '1;
    else      mask_q <= mask_d;
  end

endmodule

// File: rtl/dispatch_tagger.sv
// rtl/dispatch_tagger.sv - renames micro-op registers to result tags and forwards them to the issue buffer
module dispatch_tagger
  import dispatch_tagger_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 35,
  parameter int NUM_TAGS      = 10,
  parameter int ARCH_REGS     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PAYLOAD_WIDTH-1:0]    din_payload,
  input  logic [2:0]                  din_src_a,
  input  logic [2:0]                  din_src_b,
  input  logic [2:0]                  din_dst,
  input  logic                        din_dst_en,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic [PAYLOAD_WIDTH+11:0]   dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  input  logic                        cpl_valid,
  input  logic [TAG_W-1:0]            cpl_tag,
  input  logic                        free_valid,
  input  logic [TAG_W-1:0]            free_tag,
  output logic [NUM_TAGS-1:0]         done_flags
);

  localparam int DOUT_W = PAYLOAD_WIDTH + TAG_FIELDS_W;

  logic [DOUT_W-1:0]    dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic [ARCH_REGS-1:0] map_valid_q, map_valid_d;
  logic [TAG_W-1:0]     map_tag_q [ARCH_REGS];
  logic [TAG_W-1:0]     map_tag_d [ARCH_REGS];
  logic [NUM_TAGS-1:0]  done_q, done_d;

  logic             pool_empty;
  logic [TAG_W-1:0] alloc_tag;
  logic             accept, alloc_en, free_ok, cpl_ok;
  logic [TAG_W-1:0] src_a_tag, src_b_tag, dst_tag;

  assign din_ready = rst && (!dout_valid_q || dout_ready) && !pool_empty;
  assign accept    = din_valid && din_ready;
  assign alloc_en  = accept && din_dst_en;
  assign free_ok   = free_valid && tag_in_range(free_tag, NUM_TAGS);
  assign cpl_ok    = cpl_valid && tag_in_range(cpl_tag, NUM_TAGS);

  tag_free_pool #(.NUM_TAGS(NUM_TAGS)) u_pool (
    .clk       (clk),
    .rst       (rst),
    .alloc_en  (alloc_en),
    .alloc_tag (alloc_tag),
    .empty     (pool_empty),
    .free_en   (free_valid),
    .free_tag  (free_tag)
  );

  // Sources read the registered map, so src == dst sees the older producer.
  assign src_a_tag = map_valid_q[din_src_a] ? map_tag_q[din_src_a] : NO_TAG;
  assign src_b_tag = map_valid_q[din_src_b] ? map_tag_q[din_src_b] : NO_TAG;
  assign dst_tag   = din_dst_en ? alloc_tag : NO_TAG;

  always_comb begin
    map_valid_d  = map_valid_q;
    map_tag_d    = map_tag_q;
    done_d       = done_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    if (cpl_ok) done_d[cpl_tag] = 1'b1;
    if (free_ok) begin
      done_d[free_tag] = 1'b1;
      for (int i = 0; i < ARCH_REGS; i++) begin
        if (map_tag_q[i] == free_tag) map_valid_d[i] = 1'b0;
      end
    end
    // Applied after the free so a same-cycle rename of the entry survives.
    if (alloc_en) begin
      done_d[alloc_tag]      = 1'b0;
      map_valid_d[din_dst]   = 1'b1;
      map_tag_d[din_dst]     = alloc_tag;
    end

    if (accept) begin
      dout_d       = {din_payload, src_a_tag, src_b_tag, dst_tag};
      dout_valid_d = 1'b1;
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      map_valid_q  <= '0;
      done_q       <= '1;
      for (int i = 0; i < ARCH_REGS; i++) map_tag_q[i] <= NO_TAG;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      map_valid_q  <= map_valid_d;
      map_tag_q    <= map_tag_d;
      done_q       <= done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign done_flags = done_q;

endmodule

// File: tb/tb_dispatch_tagger.sv
// tb/tb_dispatch_tagger.sv - scoreboard bench for dispatch_tagger with directed rename vectors
module tb_dispatch_tagger;

  logic        clk = 1'b0;
  logic        rst;
  logic [34:0] din_payload;
  logic [2:0]  din_src_a, din_src_b, din_dst;
  logic        din_dst_en, din_valid, din_ready;
  logic [46:0] dout;
  logic        dout_valid, dout_ready;
  logic        cpl_valid, free_valid;
  logic [3:0]  cpl_tag, free_tag;
  logic [9:0]  done_flags;

  int checks = 0;
  int failures = 0;
  logic [46:0] exp_q [$];

  dispatch_tagger dut (
    .clk(clk), .rst(rst),
    .din_payload(din_payload), .din_src_a(din_src_a), .din_src_b(din_src_b),
    .din_dst(din_dst), .din_dst_en(din_dst_en), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .free_valid(free_valid), .free_tag(free_tag),
    .done_flags(done_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dout_unexpected actual=%0h expected=none", dout);
      end else begin
        chk("dout", 64'(dout), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [34:0] pl, input logic [2:0] sa, input logic [2:0] sb,
                      input logic [2:0] d, input logic de,
                      input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] ed,
                      input bit push);
    din_payload = pl; din_src_a = sa; din_src_b = sb; din_dst = d; din_dst_en = de;
    din_valid = 1'b1;
    for (int n = 0; n <= 50; n++) begin
      @(negedge clk);
      if (din_ready) break;
      if (n == 50) chk("din_ready_timeout", 64'(din_ready), 64'd1);
    end
    if (push && din_ready) exp_q.push_back({pl, ea, eb, ed});
    step();
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_din_ready", 64'(din_ready), 64'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("reset_dout_valid", 64'(dout_valid), 64'd0);
    chk("reset_dout", 64'(dout), 64'd0);
    chk("reset_done_flags", 64'(done_flags), 64'h3FF);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [3:0] ea [10];
    logic [3:0] eb [10];
    ea = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8};
    eb = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h7, 4'h7};

    rst = 1'b0; din_payload = '0; din_src_a = '0; din_src_b = '0; din_dst = '0;
    din_dst_en = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    cpl_valid = 1'b0; cpl_tag = '0; free_valid = 1'b0; free_tag = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // First dispatch and ten-tag exhaustion.
    send(35'h100, 3'd1, 3'd2, 3'd0, 1'b1, ea[0], eb[0], 4'h0, 1'b1);
    @(negedge clk);
    chk("done_after_first", 64'(done_flags), 64'h3FE);
    step();
    for (int k = 1; k < 10; k++)
      send(35'h100 + 35'(k), 3'd0, 3'd7, 3'(k), 1'b1, ea[k], eb[k], 4'(k), 1'b1);
    @(negedge clk);
    chk("pool_empty_din_ready", 64'(din_ready), 64'd0);
    chk("pool_empty_done", 64'(done_flags), 64'h000);
    step();
    free_valid = 1'b1; free_tag = 4'd3;
    @(negedge clk);
    chk("free_cycle_din_ready", 64'(din_ready), 64'd0);
    step();
    free_valid = 1'b0;
    @(negedge clk);
    chk("after_free_din_ready", 64'(din_ready), 64'd1);
    chk("after_free_done", 64'(done_flags), 64'h008);
    step();
    send(35'h200, 3'd3, 3'd2, 3'd2, 1'b1, 4'hF, 4'h2, 4'h3, 1'b1);

    // Source equal to destination, then a stall with a waiting op.
    do_reset();
    send(35'h300, 3'd0, 3'd0, 3'd1, 1'b1, 4'hF, 4'hF, 4'h0, 1'b1);
    send(35'h301, 3'd1, 3'd3, 3'd1, 1'b1, 4'h0, 4'hF, 4'h1, 1'b1);
    send(35'h302, 3'd1, 3'd1, 3'd1, 1'b0, 4'h1, 4'h1, 4'hF, 1'b1);
    @(negedge clk);
    chk("done_after_c", 64'(done_flags), 64'h3FC);
    step();
    dout_ready = 1'b0;
    send(35'h303, 3'd1, 3'd0, 3'd5, 1'b1, 4'h1, 4'hF, 4'h2, 1'b1);
    din_payload = 35'h304; din_src_a = 3'd5; din_src_b = 3'd5; din_dst = 3'd6;
    din_dst_en = 1'b1; din_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("stall_din_ready", 64'(din_ready), 64'd0);
      chk("stall_dout", 64'(dout), 64'({35'h303, 4'h1, 4'hF, 4'h2}));
      chk("stall_done", 64'(done_flags), 64'h3F8);
    end
    step();
    dout_ready = 1'b1;
    @(negedge clk);
    chk("release_din_ready", 64'(din_ready), 64'd1);
    exp_q.push_back({35'h304, 4'h2, 4'h2, 4'h3});
    step();
    din_valid = 1'b0;
    @(negedge clk);
    chk("done_after_e", 64'(done_flags), 64'h3F0);
    step();

    // Completion, free and accept in the same cycle.
    do_reset();
    send(35'h400, 3'd0, 3'd0, 3'd4, 1'b1, 4'hF, 4'hF, 4'h0, 1'b1);
    send(35'h401, 3'd4, 3'd4, 3'd5, 1'b1, 4'h0, 4'h0, 4'h1, 1'b1);
    send(35'h402, 3'd0, 3'd0, 3'd2, 1'b1, 4'hF, 4'hF, 4'h2, 1'b1);
    cpl_valid = 1'b1; cpl_tag = 4'd2; free_valid = 1'b1; free_tag = 4'd0;
    send(35'h403, 3'd4, 3'd2, 3'd3, 1'b1, 4'h0, 4'h2, 4'h3, 1'b1);
    cpl_valid = 1'b0; free_valid = 1'b0;
    @(negedge clk);
    chk("done_same_cycle", 64'(done_flags), 64'h3F5);
    step();
    send(35'h404, 3'd4, 3'd3, 3'd0, 1'b0, 4'hF, 4'h3, 4'hF, 1'b1);
    send(35'h405, 3'd2, 3'd2, 3'd6, 1'b1, 4'h2, 4'h2, 4'h0, 1'b1);
    @(negedge clk);
    chk("done_after_l", 64'(done_flags), 64'h3F4);
    step();
    cpl_valid = 1'b1; cpl_tag = 4'd1; free_valid = 1'b1; free_tag = 4'hF;
    step();
    cpl_tag = 4'hA; free_tag = 4'hC;
    @(negedge clk);
    chk("done_cpl_one", 64'(done_flags), 64'h3F6);
    step();
    cpl_valid = 1'b0; free_valid = 1'b0;
    @(negedge clk);
    chk("done_ignored_tags", 64'(done_flags), 64'h3F6);
    chk("din_ready_ignored_tags", 64'(din_ready), 64'd1);
    step();

    // Reset while an output is held and five tags are live.
    dout_ready = 1'b0;
    send(35'h500, 3'd7, 3'd7, 3'd6, 1'b1, 4'hF, 4'hF, 4'h4, 1'b0);
    @(negedge clk);
    chk("held_dout_valid", 64'(dout_valid), 64'd1);
    chk("held_dout", 64'(dout), 64'({35'h500, 4'hF, 4'hF, 4'h4}));
    do_reset();
    dout_ready = 1'b1;
    send(35'h501, 3'd6, 3'd1, 3'd1, 1'b1, 4'hF, 4'hF, 4'h0, 1'b1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dispatch_tagger.md
DISPATCH_TAGGER -- requirements
Module: dispatch_tagger

Interface
REQ-001 SHALL have parameter PAYLOAD_WIDTH, default 35, meaning width of decoded micro-op payload passed through untouched.
REQ-002 SHALL have parameter NUM_TAGS, default 10, meaning number of result tags, equal to the done_flags width.
REQ-003 SHALL have parameter ARCH_REGS, default 8, meaning number of architectural register/flag groups tracked by the map table.
REQ-004 SHALL use one clock and a synchronous, active-low reset, with these ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset.
- din_payload  input  PAYLOAD_WIDTH  micro-op payload.
- din_src_a  input  3  architectural source A index.
- din_src_b  input  3  architectural source B index.
- din_dst  input  3  architectural destination index.
- din_dst_en  input  1  micro-op writes din_dst.
- din_valid  input  1  upstream offer.
- din_ready  output  1  dispatcher accepts this cycle.
- dout  output  PAYLOAD_WIDTH+12  {payload, src_a_tag[3:0], src_b_tag[3:0], dst_tag[3:0]} to the sequential issue buffer.
- dout_valid  output  1  dout holds an instruction.
- dout_ready  input  1  issue buffer accepts.
- cpl_valid  input  1  execution result produced.
- cpl_tag  input  4  tag of that result.
- free_valid  input  1  tag retired and returned.
- free_tag  input  4  tag to return.
- done_flags  output  NUM_TAGS  bit i = 1 when tag i is complete or free.

Function
REQ-005 Tag value 4'hF (NO_TAG) SHALL mean "no dependency"; consumers treat it as ready.
REQ-006 The map table SHALL hold, per architectural index, a valid bit and a 4-bit tag; an invalid entry reads as NO_TAG.
REQ-007 A free pool SHALL be kept as a NUM_TAGS-bit mask; allocation SHALL pick the lowest-numbered free tag.
REQ-008 din_ready SHALL be (!dout_valid || dout_ready) && (free pool non-empty), and SHALL NOT depend on din_valid or din_dst_en.
REQ-009 On accept (din_valid && din_ready), the output register SHALL load next edge, giving 1-cycle latency:
- src tags from the map table as it stood before this cycle's update.
- dst_tag equal to the allocated tag when din_dst_en is set, else NO_TAG.
REQ-010 On accept with din_dst_en set, the block SHALL:
- remove the allocated tag from the pool.
- clear its done flag.
- set map[din_dst] to {valid, tag}.
REQ-011 On accept with din_dst_en clear, the block SHALL allocate no tag.
REQ-012 When a micro-op has din_src_a or din_src_b equal to din_dst, the source SHALL receive the previous mapping.
REQ-013 dout_valid SHALL clear after dout_ready when no new accept occurs that cycle; dout SHALL hold stable while dout_valid && !dout_ready.
REQ-014 cpl_valid SHALL set done_flags[cpl_tag] at the next edge; map and pool SHALL be unchanged.
REQ-015 free_valid SHALL return free_tag to the pool and set its done flag at the next edge, and SHALL invalidate every map entry still pointing at free_tag.
REQ-016 A tag freed in cycle N SHALL first be allocatable in cycle N+1; din_ready SHALL use the pre-update pool.
REQ-017 When the same-cycle allocation writes the same map entry that a free invalidates, the allocation SHALL win.
REQ-018 cpl_tag or free_tag values >= NUM_TAGS, including NO_TAG, SHALL be ignored.
REQ-019 cpl, free and accept in the same cycle SHALL all take effect independently.

Reset
REQ-020 While rst=0 at an edge, the block SHALL reset to:
- dout_valid=0, dout=0.
- all map entries invalid.
- all tags in the pool.
- done_flags all 1s.
- din_ready=0 during the reset cycle.
REQ-021 Reset mid-operation SHALL discard the held output and all in-flight tags with no partial update.

Structure
REQ-022 A shared package SHALL hold NO_TAG, tag width (4), the dout field offsets and the instruction width (PAYLOAD_WIDTH+12 = 47).
REQ-023 A sub-module tag_free_pool SHALL hold the mask, the lowest-free priority encoder, the empty flag, and the allocate/free ports.

Verification
REQ-024 Reset, then dispatch dst_en=1, dst=0, src=1/2 -> next cycle dout tags {F,F,0}, done_flags=10'h3FE.
REQ-025 Dispatch 10 dst-writing ops with dout_ready=1 -> tags 0..9 in order, then din_ready=0; one free_valid tag 3 -> din_ready=1 next cycle, next op gets tag 3.
REQ-026 Op A writes dst 1 (tag 0); op B has src_a=1 and dst=1 -> B src_a_tag=0, B dst_tag=1; map[1]=1.
REQ-027 Hold dout_ready=0 with din_valid=1 -> dout stable, din_ready=0, no tag consumed; release -> resumes with no loss or duplicate.
REQ-028 Same cycle: cpl tag 2, free tag 0 (still mapped by dst 4), accept op -> done[2]=1, done[0]=1, map[4] invalid, new op gets tag other than 0.
REQ-029 Assert rst=0 while dout_valid=1 and 5 tags allocated -> next cycle dout_valid=0, done_flags=10'h3FF, first post-reset op gets tag 0.
